// File: rtl/vending_credit_ctrl.sv
// vending_credit_ctrl: credit balance keeper and product/change dispenser.
// Accepts one-clock coin, select and return pulses; answers with one-clock
// product, change and reject pulses. Change is paid one coin per cycle,
// largest denomination first.
//
// Interface timing: every *_pulse input is a single-cycle strobe sampled on
// the rising edge; there is no back-pressure, so a pulse that cannot be
// honoured (unaffordable select, select/return while paying out) is dropped,
// and a coin that cannot be credited is reported on reject.
module vending_credit_ctrl #(
    parameter int COIN0_VAL = 100,
    parameter int COIN1_VAL = 500,
    parameter int COIN2_VAL = 1000,
    parameter int COIN3_VAL = 5000,
    parameter int PRICE0    = 300,
    parameter int PRICE1    = 700,
    parameter int PRICE2    = 1200,
    parameter int PRICE3    = 2500,
    parameter int MAX_BAL   = 9900,
    parameter int BAL_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       moneyin_pulse,
    input  logic [3:0]       select_pulse,
    input  logic             return_pulse,
    output logic [BAL_W-1:0] balance,
    output logic [3:0]       avail,
    output logic [3:0]       product_out,
    output logic [3:0]       change_out,
    output logic             reject,
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } state_t;

    localparam logic [BAL_W-1:0] C0  = BAL_W'(COIN0_VAL);
    localparam logic [BAL_W-1:0] C1  = BAL_W'(COIN1_VAL);
    localparam logic [BAL_W-1:0] C2  = BAL_W'(COIN2_VAL);
    localparam logic [BAL_W-1:0] C3  = BAL_W'(COIN3_VAL);
    localparam logic [BAL_W-1:0] P0  = BAL_W'(PRICE0);
    localparam logic [BAL_W-1:0] P1  = BAL_W'(PRICE1);
    localparam logic [BAL_W-1:0] P2  = BAL_W'(PRICE2);
    localparam logic [BAL_W-1:0] P3  = BAL_W'(PRICE3);
    localparam logic [BAL_W:0]   MAX = (BAL_W+1)'(MAX_BAL);

    state_t           state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [3:0]       product_q, product_d;
    logic [3:0]       change_q, change_d;
    logic             reject_q, reject_d;

    // Decoded coin / select / payout-choice signals
    logic [BAL_W-1:0] coin_val;
    logic             coin_any;
    logic             coin_extra;
    logic             coin_fit;
    logic [BAL_W:0]   coin_sum;
    logic [BAL_W-1:0] credit_total;
    logic [BAL_W-1:0] price;
    logic [3:0]       sel_onehot;
    logic             sel_ok;
    logic [BAL_W-1:0] pay_val;
    logic [3:0]       pay_onehot;

    // Lowest-index coin wins; any higher coin in the same pulse is extra
    always_comb begin
        coin_val   = '0;
        coin_extra = 1'b0;
        coin_any   = |moneyin_pulse;
        if (moneyin_pulse[0]) begin
            coin_val   = C0;
            coin_extra = |moneyin_pulse[3:1];
        end else if (moneyin_pulse[1]) begin
            coin_val   = C1;
            coin_extra = |moneyin_pulse[3:2];
        end else if (moneyin_pulse[2]) begin
            coin_val   = C2;
            coin_extra = moneyin_pulse[3];
        end else if (moneyin_pulse[3]) begin
            coin_val   = C3;
        end
        coin_sum     = {1'b0, balance_q} + {1'b0, coin_val};
        coin_fit     = coin_any && (coin_sum <= MAX);
        credit_total = coin_fit ? coin_sum[BAL_W-1:0] : balance_q;
    end

    // Lowest-index select wins; affordability uses the pre-edge balance only
    always_comb begin
        price      = '0;
        sel_onehot = 4'b0000;
        if (select_pulse[0]) begin
            price      = P0;
            sel_onehot = 4'b0001;
        end else if (select_pulse[1]) begin
            price      = P1;
            sel_onehot = 4'b0010;
        end else if (select_pulse[2]) begin
            price      = P2;
            sel_onehot = 4'b0100;
        end else if (select_pulse[3]) begin
            price      = P3;
            sel_onehot = 4'b1000;
        end
        sel_ok = (|select_pulse) && (balance_q >= price);
    end

    // Largest coin not exceeding the balance; balance is a multiple of C0
    always_comb begin
        pay_val    = '0;
        pay_onehot = 4'b0000;
        if (balance_q >= C3) begin
            pay_val    = C3;
            pay_onehot = 4'b1000;
        end else if (balance_q >= C2) begin
            pay_val    = C2;
            pay_onehot = 4'b0100;
        end else if (balance_q >= C1) begin
            pay_val    = C1;
            pay_onehot = 4'b0010;
        end else if (balance_q >= C0) begin
            pay_val    = C0;
            pay_onehot = 4'b0001;
        end
    end

    // Next-state and next-output logic for the IDLE/CHANGE controller
    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        product_d = 4'b0000;
        change_d  = 4'b0000;
        reject_d  = 1'b0;
        case (state_q)
            IDLE: begin
                reject_d  = coin_extra || (coin_any && !coin_fit);
                balance_d = credit_total;
                if (return_pulse) begin
                    // Same-cycle select is dropped; accepted coin is refunded
                    if (credit_total != '0) begin
                        state_d = CHANGE;
                    end
                end else if (sel_ok) begin
                    product_d = sel_onehot;
                    balance_d = credit_total - price;
                end
            end
            CHANGE: begin
                reject_d  = coin_any;
                change_d  = pay_onehot;
                balance_d = balance_q - pay_val;
                if (balance_q == pay_val) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset also abandons any payout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            balance_q <= '0;
            product_q <= 4'b0000;
            change_q  <= 4'b0000;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            product_q <= product_d;
            change_q  <= change_d;
            reject_q  <= reject_d;
        end
    end

    assign balance     = balance_q;
    assign product_out = product_q;
    assign change_out  = change_q;
    assign reject      = reject_q;
    assign busy        = (state_q != IDLE);
    assign avail       = (state_q == IDLE) ?
                         {balance_q >= P3, balance_q >= P2,
                          balance_q >= P1, balance_q >= P0} : 4'b0000;

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// Directed testbench for vending_credit_ctrl with hand-computed expectations.
module tb_vending_credit_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  moneyin_pulse;
    logic [3:0]  select_pulse;
    logic        return_pulse;
    logic [15:0] balance;
    logic [3:0]  avail;
    logic [3:0]  product_out;
    logic [3:0]  change_out;
    logic        reject;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    vending_credit_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .moneyin_pulse (moneyin_pulse),
        .select_pulse  (select_pulse),
        .return_pulse  (return_pulse),
        .balance       (balance),
        .avail         (avail),
        .product_out   (product_out),
        .change_out    (change_out),
        .reject        (reject),
        .busy          (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Drive one cycle of pulses (called 1 time unit after a rising edge);
    // returns 1 time unit after the next rising edge with inputs cleared.
    task automatic step(input logic [3:0] coin, input logic [3:0] sel, input logic ret);
        moneyin_pulse = coin;
        select_pulse  = sel;
        return_pulse  = ret;
        @(posedge clk);
        #1;
        moneyin_pulse = 4'b0000;
        select_pulse  = 4'b0000;
        return_pulse  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        moneyin_pulse = 4'b0000;
        select_pulse  = 4'b0000;
        return_pulse  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_balance", 32'(balance), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_product", 32'(product_out), 0);
        check("rst_change", 32'(change_out), 0);
        check("rst_reject", 32'(reject), 0);
        check("rst_avail", 32'(avail), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Return with nothing to pay: stays idle
        step(4'b0000, 4'b0000, 1'b1);
        check("ret0_busy", 32'(busy), 0);
        idle_cycles(1);
        check("ret0_change", 32'(change_out), 0);

        // Coin crediting
        step(4'b0001, 4'b0000, 1'b0);
        check("c0_bal", 32'(balance), 100);
        check("c0_rej", 32'(reject), 0);
        check("c0_avail", 32'(avail), 4'b0000);
        step(4'b0010, 4'b0000, 1'b0);
        check("c1_bal", 32'(balance), 600);
        check("c1_rej", 32'(reject), 0);
        step(4'b0100, 4'b0000, 1'b0);
        check("c2_bal", 32'(balance), 1600);
        check("c2_rej", 32'(reject), 0);
        check("c2_avail", 32'(avail), 4'b0111);

        // Select product 2, then an unaffordable product 1
        step(4'b0000, 4'b0100, 1'b0);
        check("sel2_prod", 32'(product_out), 4'b0100);
        check("sel2_bal", 32'(balance), 400);
        idle_cycles(1);
        check("sel2_prod_gone", 32'(product_out), 0);
        step(4'b0000, 4'b0010, 1'b0);
        check("sel1_ignored_prod", 32'(product_out), 0);
        check("sel1_ignored_bal", 32'(balance), 400);

        // Build up to 9500: +5000, +4*1000, +100
        step(4'b1000, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0100, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("fill_bal", 32'(balance), 9500);
        check("fill_avail", 32'(avail), 4'b1111);

        // Overflowing coin is rejected
        step(4'b0100, 4'b0000, 1'b0);
        check("ovf_rej", 32'(reject), 1);
        check("ovf_bal", 32'(balance), 9500);
        idle_cycles(1);
        check("ovf_rej_gone", 32'(reject), 0);
        // Two coins at once: lowest credited, other rejected
        step(4'b0011, 4'b0000, 1'b0);
        check("dual_bal", 32'(balance), 9600);
        check("dual_rej", 32'(reject), 1);

        // Multi-select picks lowest index: 9600 - 2500 = 7100
        step(4'b0000, 4'b1000, 1'b0);
        check("sel3_prod", 32'(product_out), 4'b1000);
        check("sel3_bal", 32'(balance), 7100);
        step(4'b0000, 4'b1010, 1'b0);
        check("multi_sel_prod", 32'(product_out), 4'b0010);
        check("multi_sel_bal", 32'(balance), 6400);
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("pre_ret_bal", 32'(balance), 6600);

        // Payout of 6600: 5000, 1000, 500, 100; select during payout ignored
        step(4'b0000, 4'b0001, 1'b1);
        check("ret_busy", 32'(busy), 1);
        check("ret_change", 32'(change_out), 0);
        check("ret_prod", 32'(product_out), 0);
        check("ret_avail", 32'(avail), 0);
        step(4'b0000, 4'b0001, 1'b0);
        check("pay1_change", 32'(change_out), 4'b1000);
        check("pay1_bal", 32'(balance), 1600);
        check("pay1_busy", 32'(busy), 1);
        check("pay1_prod", 32'(product_out), 0);
        step(4'b0000, 4'b0000, 1'b0);
        check("pay2_change", 32'(change_out), 4'b0100);
        check("pay2_bal", 32'(balance), 600);
        check("pay2_busy", 32'(busy), 1);
        step(4'b0010, 4'b0000, 1'b0);
        check("pay3_change", 32'(change_out), 4'b0010);
        check("pay3_bal", 32'(balance), 100);
        check("pay3_rej", 32'(reject), 1);
        check("pay3_busy", 32'(busy), 1);
        step(4'b0000, 4'b0000, 1'b0);
        check("pay4_change", 32'(change_out), 4'b0001);
        check("pay4_bal", 32'(balance), 0);
        check("pay4_busy", 32'(busy), 0);
        check("pay4_rej", 32'(reject), 0);
        idle_cycles(1);
        check("pay_done_change", 32'(change_out), 0);
        check("pay_done_bal", 32'(balance), 0);

        // Coin with unaffordable select in the same cycle: 200 -> 700
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0010, 4'b0001, 1'b0);
        check("cs1_prod", 32'(product_out), 0);
        check("cs1_bal", 32'(balance), 700);
        // Return 700 with a same-cycle coin0: pays 500, 100, 100, 100
        step(4'b0001, 4'b0000, 1'b1);
        check("retcoin_bal", 32'(balance), 800);
        step(4'b0000, 4'b0000, 1'b0);
        check("retcoin_pay1", 32'(change_out), 4'b0010);
        idle_cycles(3);
        check("retcoin_pay4", 32'(change_out), 4'b0001);
        check("retcoin_bal0", 32'(balance), 0);
        check("retcoin_busy", 32'(busy), 0);

        // Same case at 300: product 0 fires, balance 300 + 500 - 300 = 500
        for (int i = 0; i < 3; i++) step(4'b0001, 4'b0000, 1'b0);
        step(4'b0010, 4'b0001, 1'b0);
        check("cs2_prod", 32'(product_out), 4'b0001);
        check("cs2_bal", 32'(balance), 500);

        // Reset in the middle of a payout of 5500
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b0);
        check("mid_pay_change", 32'(change_out), 4'b1000);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_change", 32'(change_out), 0);
        check("mid_rst_bal", 32'(balance), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_reject", 32'(reject), 0);
        check("mid_rst_prod", 32'(product_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(3);
        check("post_rst_change", 32'(change_out), 0);
        check("post_rst_bal", 32'(balance), 0);
        check("post_rst_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
